// File: rtl/xy_response_checker_pkg.sv
// Shared types for the xy_response_checker slice: FSM states and the {x,y} sample type.
package xy_chk_pkg;

    localparam int XY_W = 2;

    typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

    typedef struct packed {
        logic x;
        logic y;
    } xy_t;

endpackage

// File: rtl/xy_response_checker_if.sv
// Table-load, start, DUT-sample and result bundle between a test harness (master) and the checker (slave).
interface xy_response_checker_if #(
    parameter int DEPTH = 16
);
    import xy_chk_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic            exp_we;
    logic [AW-1:0]   exp_addr;
    logic [XY_W-1:0] exp_data;
    logic [XY_W-1:0] exp_mask;
    logic [AW:0]     num_vec;
    logic            start;
    logic            x;
    logic            y;
    logic            busy;
    logic            done;
    logic            pass;
    logic [AW:0]     err_cnt;
    logic            first_err_vld;
    logic [AW-1:0]   first_err_idx;
    logic [XY_W-1:0] first_err_xy;

    modport master (
        output exp_we, exp_addr, exp_data, exp_mask, num_vec, start, x, y,
        input  busy, done, pass, err_cnt, first_err_vld, first_err_idx, first_err_xy
    );

    modport slave (
        input  exp_we, exp_addr, exp_data, exp_mask, num_vec, start, x, y,
        output busy, done, pass, err_cnt, first_err_vld, first_err_idx, first_err_xy
    );

endinterface

// File: rtl/xy_response_checker_exp_mem.sv
// Expected-vector table: sync write, async read. Mask array only exists with XY_MASK_EN defined.
module xy_exp_mem
    import xy_chk_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  xy_t           i_wdata,
    input  xy_t           i_wmask,
    input  logic [AW-1:0] i_raddr,
    output xy_t           o_rdata,
    output xy_t           o_rmask
);

    xy_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

`ifdef XY_MASK_EN
    xy_t r_mask [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mask[i_waddr] <= i_wmask;
    end

    assign o_rmask = r_mask[i_raddr];
`else
    logic w_unused_mask;

    assign w_unused_mask = ^i_wmask;
    assign o_rmask       = '0;
`endif

endmodule

// File: rtl/xy_response_checker.sv
// Samples DUT {x,y} once per clock after start, compares against the expected table,
// counts mismatches and captures the first one. Optional per-bit masking: XY_MASK_EN.
module xy_response_checker
    import xy_chk_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    xy_response_checker_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);

    state_t        r_state, w_state_nxt;
    logic [AW:0]   r_n, r_err_cnt;
    logic [AW-1:0] r_idx, r_first_idx;
    logic          r_first_vld;
    xy_t           r_first_xy;

    xy_t           w_obs, w_exp, w_mask;
    logic          w_mis, w_last, w_start, w_we;
    logic [AW:0]   w_n_lat;

    // Table writes are blocked only while a check is running so vectors stay stable.
    assign w_we    = bus.exp_we && (r_state != CHECK);
    assign w_start = bus.start  && (r_state != CHECK);
    assign w_n_lat = (bus.num_vec > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.num_vec;

    xy_exp_mem #(.DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (bus.exp_addr),
        .i_wdata (xy_t'(bus.exp_data)),
        .i_wmask (xy_t'(bus.exp_mask)),
        .i_raddr (r_idx),
        .o_rdata (w_exp),
        .o_rmask (w_mask)
    );

    assign w_obs  = xy_t'({bus.x, bus.y});
    assign w_mis  = |((w_obs ^ w_exp) & ~w_mask);
    assign w_last = ({1'b0, r_idx} == (r_n - 1'b1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE: if (bus.start) w_state_nxt = (bus.num_vec == '0) ? DONE : CHECK;
            CHECK:      if (w_last)    w_state_nxt = DONE;
            default:                   w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_n         <= '0;
            r_idx       <= '0;
            r_err_cnt   <= '0;
            r_first_vld <= 1'b0;
            r_first_idx <= '0;
            r_first_xy  <= '0;
        end else if (w_start) begin
            r_n         <= w_n_lat;
            r_idx       <= '0;
            r_err_cnt   <= '0;
            r_first_vld <= 1'b0;
            r_first_idx <= '0;
            r_first_xy  <= '0;
        end else if (r_state == CHECK) begin
            r_idx <= r_idx + 1'b1;
            if (w_mis) begin
                r_err_cnt <= r_err_cnt + 1'b1;
                if (!r_first_vld) begin
                    r_first_vld <= 1'b1;
                    r_first_idx <= r_idx;
                    r_first_xy  <= w_obs;
                end
            end
        end
    end

    assign bus.busy          = (r_state == CHECK);
    assign bus.done          = (r_state == DONE);
    assign bus.pass          = (r_state == DONE) && (r_err_cnt == '0);
    assign bus.err_cnt       = r_err_cnt;
    assign bus.first_err_vld = r_first_vld;
    assign bus.first_err_idx = r_first_idx;
    assign bus.first_err_xy  = r_first_xy;

endmodule

// File: tb/tb_xy_response_checker.sv
// Directed-vector bench for xy_response_checker (DEPTH=16); mask scenario follows XY_MASK_EN.
module tb_xy_response_checker;

    logic clk;
    logic rstn;
    int   n_chk;
    int   n_fail;

    logic [1:0] tab [16];
    logic [1:0] obs [32];

    xy_response_checker_if #(.DEPTH(16)) bus ();

    xy_response_checker #(.DEPTH(16)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_table;
        for (int i = 0; i < 16; i++) begin
            bus.exp_we   = 1'b1;
            bus.exp_addr = 4'(i);
            bus.exp_data = tab[i];
            bus.exp_mask = 2'b00;
            tick();
        end
        bus.exp_we = 1'b0;
    endtask

    task automatic do_start(input int nv);
        bus.num_vec = 5'(nv);
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
    endtask

    task automatic step(input int k);
        {bus.x, bus.y} = obs[k];
        tick();
    endtask

    task automatic obs_from_tab;
        for (int i = 0; i < 32; i++) obs[i] = tab[i % 16];
    endtask

    task automatic test_reset;
        n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
        n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", bus.done); end
        n_chk++; if (bus.pass !== 1'b0) begin n_fail++; $display("FAIL reset_pass: got %0b want 0", bus.pass); end
        n_chk++; if (bus.err_cnt !== 5'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d want 0", bus.err_cnt); end
        n_chk++; if (bus.first_err_vld !== 1'b0) begin n_fail++; $display("FAIL reset_first_vld: got %0b want 0", bus.first_err_vld); end
        n_chk++; if (bus.first_err_idx !== 4'd0 || bus.first_err_xy !== 2'd0) begin
            n_fail++; $display("FAIL reset_first_err: got idx %0d xy %b want 0/00", bus.first_err_idx, bus.first_err_xy);
        end
    endtask

    task automatic test_all_pass;
        load_table();
        obs_from_tab();
        do_start(8);
        n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL pass_busy_start: got %0b want 1", bus.busy); end
        for (int k = 0; k < 7; k++) step(k);
        n_chk++; if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL pass_early_done: got done %0b busy %0b want 0/1", bus.done, bus.busy);
        end
        step(7);
        n_chk++; if (bus.done !== 1'b1 || bus.pass !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL pass_done: got done %0b pass %0b busy %0b want 1/1/0", bus.done, bus.pass, bus.busy);
        end
        n_chk++; if (bus.err_cnt !== 5'd0 || bus.first_err_vld !== 1'b0) begin
            n_fail++; $display("FAIL pass_err: got cnt %0d vld %0b want 0/0", bus.err_cnt, bus.first_err_vld);
        end
    endtask

    task automatic test_errors;
        obs_from_tab();
        obs[2] = 2'b11;
        obs[5] = 2'b00;
        do_start(8);
        for (int k = 0; k < 8; k++) step(k);
        n_chk++; if (bus.err_cnt !== 5'd2) begin n_fail++; $display("FAIL err_cnt2: got %0d want 2", bus.err_cnt); end
        n_chk++; if (bus.first_err_vld !== 1'b1 || bus.first_err_idx !== 4'd2 || bus.first_err_xy !== 2'b11) begin
            n_fail++; $display("FAIL err_first: got vld %0b idx %0d xy %b want 1/2/11",
                               bus.first_err_vld, bus.first_err_idx, bus.first_err_xy);
        end
        n_chk++; if (bus.done !== 1'b1 || bus.pass !== 1'b0) begin
            n_fail++; $display("FAIL err_pass: got done %0b pass %0b want 1/0", bus.done, bus.pass);
        end
    endtask

    task automatic test_bounds;
        do_start(0);
        n_chk++; if (bus.done !== 1'b1 || bus.pass !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL zero_done: got done %0b pass %0b busy %0b want 1/1/0", bus.done, bus.pass, bus.busy);
        end
        n_chk++; if (bus.err_cnt !== 5'd0 || bus.first_err_vld !== 1'b0) begin
            n_fail++; $display("FAIL zero_clear: got cnt %0d vld %0b want 0/0", bus.err_cnt, bus.first_err_vld);
        end
        obs_from_tab();
        obs[15] = tab[15] ^ 2'b11;
        do_start(20);
        for (int k = 0; k < 15; k++) step(k);
        n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL clamp_busy15: got %0b want 1", bus.busy); end
        step(15);
        n_chk++; if (bus.done !== 1'b1 || bus.err_cnt !== 5'd1 || bus.first_err_idx !== 4'd15) begin
            n_fail++; $display("FAIL clamp_done: got done %0b cnt %0d idx %0d want 1/1/15",
                               bus.done, bus.err_cnt, bus.first_err_idx);
        end
        for (int k = 0; k < 4; k++) begin
            {bus.x, bus.y} = ~tab[k];
            tick();
        end
        n_chk++; if (bus.done !== 1'b1 || bus.err_cnt !== 5'd1) begin
            n_fail++; $display("FAIL clamp_hold: got done %0b cnt %0d want 1/1", bus.done, bus.err_cnt);
        end
    endtask

    task automatic test_reset_mid;
        obs_from_tab();
        obs[1] = ~tab[1];
        do_start(8);
        for (int k = 0; k < 3; k++) step(k);
        n_chk++; if (bus.err_cnt !== 5'd1) begin n_fail++; $display("FAIL mid_pre: got %0d want 1", bus.err_cnt); end
        rstn = 1'b0;
        #1;
        n_chk++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err_cnt !== 5'd0 || bus.first_err_vld !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: got busy %0b done %0b cnt %0d vld %0b want 0/0/0/0",
                               bus.busy, bus.done, bus.err_cnt, bus.first_err_vld);
        end
        tick();
        rstn = 1'b1;
        tick();
        obs_from_tab();
        do_start(8);
        for (int k = 0; k < 8; k++) step(k);
        n_chk++; if (bus.done !== 1'b1 || bus.pass !== 1'b1 || bus.err_cnt !== 5'd0) begin
            n_fail++; $display("FAIL mid_retained: got done %0b pass %0b cnt %0d want 1/1/0", bus.done, bus.pass, bus.err_cnt);
        end
    endtask

    task automatic test_ignored;
        obs_from_tab();
        obs[6] = ~tab[6];
        do_start(8);
        for (int k = 0; k < 8; k++) begin
            if (k == 3) begin
                bus.start    = 1'b1;
                bus.num_vec  = 5'd0;
                bus.exp_we   = 1'b1;
                bus.exp_addr = 4'd4;
                bus.exp_data = 2'b00;
            end else begin
                bus.start  = 1'b0;
                bus.exp_we = 1'b0;
            end
            step(k);
        end
        n_chk++; if (bus.done !== 1'b1 || bus.err_cnt !== 5'd1 || bus.first_err_idx !== 4'd6) begin
            n_fail++; $display("FAIL ign_run: got done %0b cnt %0d idx %0d want 1/1/6", bus.done, bus.err_cnt, bus.first_err_idx);
        end
        obs_from_tab();
        do_start(8);
        for (int k = 0; k < 8; k++) step(k);
        n_chk++; if (bus.pass !== 1'b1 || bus.err_cnt !== 5'd0) begin
            n_fail++; $display("FAIL ign_table: got pass %0b cnt %0d want 1/0", bus.pass, bus.err_cnt);
        end
    endtask

    task automatic test_write_first;
        bus.exp_we   = 1'b1;
        bus.exp_addr = 4'd0;
        bus.exp_data = 2'b01;
        do_start(1);
        bus.exp_we   = 1'b0;
        {bus.x, bus.y} = 2'b01;
        tick();
        n_chk++; if (bus.done !== 1'b1 || bus.pass !== 1'b1) begin
            n_fail++; $display("FAIL wf_new: got done %0b pass %0b want 1/1", bus.done, bus.pass);
        end
        bus.exp_we   = 1'b1;
        bus.exp_data = tab[0];
        tick();
        bus.exp_we   = 1'b0;
        do_start(1);
        {bus.x, bus.y} = tab[0];
        tick();
        n_chk++; if (bus.pass !== 1'b1 || bus.err_cnt !== 5'd0) begin
            n_fail++; $display("FAIL wf_restore: got pass %0b cnt %0d want 1/0", bus.pass, bus.err_cnt);
        end
    endtask

    task automatic test_mask;
        int exp_cnt;
`ifdef XY_MASK_EN
        exp_cnt = 0;
`else
        exp_cnt = 1;
`endif
        bus.exp_we   = 1'b1;
        bus.exp_addr = 4'd1;
        bus.exp_data = tab[1];
        bus.exp_mask = 2'b01;
        tick();
        bus.exp_we   = 1'b0;
        bus.exp_mask = 2'b00;
        obs_from_tab();
        obs[1] = tab[1] ^ 2'b01;
        do_start(2);
        for (int k = 0; k < 2; k++) step(k);
        n_chk++; if (bus.done !== 1'b1 || bus.err_cnt !== 5'(exp_cnt)) begin
            n_fail++; $display("FAIL mask_cnt: got done %0b cnt %0d want 1/%0d", bus.done, bus.err_cnt, exp_cnt);
        end
        n_chk++; if (bus.pass !== (exp_cnt == 0)) begin
            n_fail++; $display("FAIL mask_pass: got %0b want %0b", bus.pass, exp_cnt == 0);
        end
    endtask

    initial begin
        clk    = 1'b0;
        rstn   = 1'b0;
        n_chk  = 0;
        n_fail = 0;
        bus.exp_we   = 1'b0;
        bus.exp_addr = '0;
        bus.exp_data = '0;
        bus.exp_mask = '0;
        bus.num_vec  = '0;
        bus.start    = 1'b0;
        bus.x        = 1'b0;
        bus.y        = 1'b0;
        tab = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b00,
                2'b11, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
        tick();
        tick();
        test_reset();
        rstn = 1'b1;
        tick();
        test_reset();
        test_all_pass();
        test_errors();
        test_bounds();
        test_reset_mid();
        test_ignored();
        test_write_first();
        test_mask();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
